// File: rtl/alu_execute_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_execute_if : handshake, operand and bus bundle for alu_execute |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface alu_execute_if #(
  parameter int WIDTH = 16
);
  logic             i_START;
  logic [2:0]       i_ALUK;
  logic [WIDTH-1:0] i_SR1;
  logic [WIDTH-1:0] i_SR2;
  logic [WIDTH-1:0] i_IR;
  logic             i_LD_CC;
  logic [WIDTH-1:0] i_bus;
  logic [WIDTH-1:0] o_RESULT;
  logic             o_BUSY;
  logic             o_DONE;
  logic             o_N;
  logic             o_Z;
  logic             o_P;

  modport master (
    output i_START, i_ALUK, i_SR1, i_SR2, i_IR, i_LD_CC, i_bus,
    input  o_RESULT, o_BUSY, o_DONE, o_N, o_Z, o_P
  );

  modport slave (
    input  i_START, i_ALUK, i_SR1, i_SR2, i_IR, i_LD_CC, i_bus,
    output o_RESULT, o_BUSY, o_DONE, o_N, o_Z, o_P
  );
endinterface
`default_nettype wire

// File: rtl/alu_execute.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_execute : LC-3 execute stage (ALU, iterative MUL, N/Z/P regs)  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module alu_execute #(
  parameter int WIDTH      = 16,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  wire logic     i_CLK,
  input  wire logic     i_RST_N,
  alu_execute_if.slave  bus_if
);

  localparam logic [1:0] c_S_IDLE    = 2'd0;
  localparam logic [1:0] c_S_MUL_RUN = 2'd1;
  localparam logic [1:0] c_S_DONE    = 2'd2;

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_AND = 3'b001;
  localparam logic [2:0] c_OP_NOT = 3'b010;
  localparam logic [2:0] c_OP_MUL = 3'b100;

  localparam logic [3:0] c_LAST_ITER = 4'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [3:0]       r_count;
  logic             r_n;
  logic             r_z;
  logic             r_p;

  logic             w_accept;
  logic             w_is_mul;
  logic             w_last_iter;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_op_b;
  logic [WIDTH-1:0] w_alu_result;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_busy;
  logic             w_done;
  logic             w_unused_ir;

  assign w_op_a = bus_if.i_SR1;
  assign w_op_b = bus_if.i_IR[5] ? {{(WIDTH-5){bus_if.i_IR[4]}}, bus_if.i_IR[4:0]}
                                 : bus_if.i_SR2;
  assign w_unused_ir = ^bus_if.i_IR[WIDTH-1:6];

  // Operands are only sampled from IDLE or DONE, so a START during MUL_RUN is dropped.
  assign w_accept    = bus_if.i_START && ((r_state == c_S_IDLE) || (r_state == c_S_DONE));
  assign w_is_mul    = ENABLE_MUL && (bus_if.i_ALUK == c_OP_MUL);
  assign w_last_iter = (r_count == c_LAST_ITER);
  assign w_acc_next  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_alu_result = w_op_a;
    case (bus_if.i_ALUK)
      c_OP_ADD: w_alu_result = w_op_a + w_op_b;
      c_OP_AND: w_alu_result = w_op_a & w_op_b;
      c_OP_NOT: w_alu_result = ~w_op_a;
      default:  w_alu_result = w_op_a;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = c_S_IDLE;
    case (r_state)
      c_S_IDLE, c_S_DONE: begin
        if (w_accept) begin
          w_state_next = w_is_mul ? c_S_MUL_RUN : c_S_DONE;
        end else begin
          w_state_next = c_S_IDLE;
        end
      end
      c_S_MUL_RUN: w_state_next = w_last_iter ? c_S_DONE : c_S_MUL_RUN;
      default:     w_state_next = c_S_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_S_MUL_RUN: w_busy = 1'b1;
      c_S_DONE:    w_done = 1'b1;
      default: begin
        w_busy = 1'b0;
        w_done = 1'b0;
      end
    endcase
  end

  // Shift-add multiplier: one multiplier bit per cycle, low WIDTH bits kept.
  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_result <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_count  <= '0;
    end else if (w_accept) begin
      if (w_is_mul) begin
        r_acc    <= '0;
        r_mcand  <= w_op_a;
        r_mplier <= w_op_b;
        r_count  <= '0;
      end else begin
        r_result <= w_alu_result;
      end
    end else if (r_state == c_S_MUL_RUN) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + 4'd1;
      if (w_last_iter) begin
        r_result <= w_acc_next;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      r_n <= 1'b0;
      r_z <= 1'b1;
      r_p <= 1'b0;
    end else if (bus_if.i_LD_CC) begin
      r_n <= bus_if.i_bus[WIDTH-1];
      r_z <= (bus_if.i_bus == '0);
      r_p <= !bus_if.i_bus[WIDTH-1] && (bus_if.i_bus != '0);
    end
  end

  assign bus_if.o_RESULT = r_result;
  assign bus_if.o_BUSY   = w_busy;
  assign bus_if.o_DONE   = w_done;
  assign bus_if.o_N      = r_n;
  assign bus_if.o_Z      = r_z;
  assign bus_if.o_P      = r_p;

endmodule
`default_nettype wire

// File: tb/tb_alu_execute.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_execute : scoreboard bench for alu_execute                  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_alu_execute;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_execute_if #(.WIDTH(16)) bif ();

  alu_execute #(.WIDTH(16), .ENABLE_MUL(1'b1)) dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .bus_if  (bif)
  );

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;

  function automatic logic [15:0] model(input logic [2:0] aluk, input logic [15:0] a,
                                        input logic [15:0] sr2, input logic [15:0] ir);
    logic [15:0] b;
    logic [15:0] r;
    b = ir[5] ? {{11{ir[4]}}, ir[4:0]} : sr2;
    case (aluk)
      3'b000:  r = a + b;
      3'b001:  r = a & b;
      3'b010:  r = ~a;
      3'b100:  r = a * b;
      default: r = a;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp();
    if (exp_q.size() > 0) exp_v = exp_q.pop_front();
    else exp_v = 16'hxxxx;
  endtask

  // Drives one START pulse and records the expected result.
  task automatic start_op(input logic [2:0] aluk, input logic [15:0] a,
                          input logic [15:0] sr2, input logic [15:0] ir);
    bif.i_ALUK  = aluk;
    bif.i_SR1   = a;
    bif.i_SR2   = sr2;
    bif.i_IR    = ir;
    bif.i_START = 1'b1;
    exp_q.push_back(model(aluk, a, sr2, ir));
    tick();
    bif.i_START = 1'b0;
  endtask

  task automatic load_cc(input logic [15:0] v);
    bif.i_bus   = v;
    bif.i_LD_CC = 1'b1;
    tick();
    bif.i_LD_CC = 1'b0;
  endtask

  task automatic test_reset();
    bif.i_START = 1'b0; bif.i_ALUK = 3'b000; bif.i_SR1 = '0; bif.i_SR2 = '0;
    bif.i_IR = '0; bif.i_LD_CC = 1'b0; bif.i_bus = '0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (bif.o_RESULT !== 16'h0000) $display("FAIL reset_result got=%h exp=0000", bif.o_RESULT); else n_pass++;
    n_total++; if (bif.o_BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", bif.o_BUSY); else n_pass++;
    n_total++; if (bif.o_DONE !== 1'b0) $display("FAIL reset_done got=%b exp=0", bif.o_DONE); else n_pass++;
    n_total++; if ({bif.o_N, bif.o_Z, bif.o_P} !== 3'b010) $display("FAIL reset_nzp got=%b exp=010", {bif.o_N, bif.o_Z, bif.o_P}); else n_pass++;
  endtask

  task automatic test_add_imm();
    start_op(3'b000, 16'h0005, 16'hAAAA, 16'h003D);
    pop_exp();
    n_total++; if (bif.o_DONE !== 1'b1) $display("FAIL add_imm_done got=%b exp=1", bif.o_DONE); else n_pass++;
    n_total++; if (bif.o_RESULT !== exp_v || exp_v !== 16'h0002) $display("FAIL add_imm_result got=%h exp=%h", bif.o_RESULT, exp_v); else n_pass++;
    tick();
    n_total++; if (bif.o_DONE !== 1'b0) $display("FAIL add_imm_done_pulse got=%b exp=0", bif.o_DONE); else n_pass++;
    n_total++; if (bif.o_RESULT !== 16'h0002) $display("FAIL add_imm_hold got=%h exp=0002", bif.o_RESULT); else n_pass++;
  endtask

  task automatic test_back_to_back();
    start_op(3'b001, 16'h00FF, 16'hF0F0, 16'h0000);
    pop_exp();
    n_total++; if (bif.o_DONE !== 1'b1 || bif.o_RESULT !== exp_v) $display("FAIL and_reg got=%h done=%b exp=%h", bif.o_RESULT, bif.o_DONE, exp_v); else n_pass++;
    start_op(3'b010, 16'h1234, 16'h0000, 16'h0000);
    pop_exp();
    n_total++; if (bif.o_DONE !== 1'b1 || bif.o_RESULT !== exp_v) $display("FAIL b2b_not got=%h done=%b exp=%h", bif.o_RESULT, bif.o_DONE, exp_v); else n_pass++;
    tick();
    n_total++; if (bif.o_DONE !== 1'b0 || bif.o_BUSY !== 1'b0) $display("FAIL b2b_idle got done=%b busy=%b exp=0/0", bif.o_DONE, bif.o_BUSY); else n_pass++;
  endtask

  task automatic test_mul();
    int busy_bad;
    busy_bad = 0;
    start_op(3'b100, 16'hFFFD, 16'h0007, 16'h0000);
    for (int k = 1; k <= 16; k++) begin
      if (bif.o_BUSY !== 1'b1 || bif.o_DONE !== 1'b0) busy_bad++;
      if (k == 2) begin
        bif.i_SR1 = 16'h1111; bif.i_SR2 = 16'h2222; bif.i_IR = 16'h003F; bif.i_ALUK = 3'b001;
      end
      if (k == 5) begin
        bif.i_START = 1'b1; bif.i_ALUK = 3'b000;
      end
      if (k == 6) bif.i_START = 1'b0;
      bif.i_LD_CC = (k == 8);
      bif.i_bus   = 16'h8000;
      tick();
    end
    bif.i_LD_CC = 1'b0;
    pop_exp();
    n_total++; if (busy_bad != 0) $display("FAIL mul_busy_window got=%0d bad cycles exp=0", busy_bad); else n_pass++;
    n_total++; if (bif.o_DONE !== 1'b1 || bif.o_BUSY !== 1'b0) $display("FAIL mul_done got done=%b busy=%b exp=1/0", bif.o_DONE, bif.o_BUSY); else n_pass++;
    n_total++; if (bif.o_RESULT !== exp_v || exp_v !== 16'hFFEB) $display("FAIL mul_result got=%h exp=%h", bif.o_RESULT, exp_v); else n_pass++;
    n_total++; if ({bif.o_N, bif.o_Z, bif.o_P} !== 3'b100) $display("FAIL cc_during_mul got=%b exp=100", {bif.o_N, bif.o_Z, bif.o_P}); else n_pass++;
    tick();
    n_total++; if (bif.o_DONE !== 1'b0 || exp_q.size() != 0) $display("FAIL mul_no_restart got done=%b q=%0d exp=0/0", bif.o_DONE, exp_q.size()); else n_pass++;
  endtask

  task automatic test_cc();
    logic [15:0] vals[4];
    logic [2:0]  exps[4];
    vals = '{16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF};
    exps = '{3'b100, 3'b010, 3'b001, 3'b100};
    for (int i = 0; i < 4; i++) begin
      load_cc(vals[i]);
      n_total++;
      if ({bif.o_N, bif.o_Z, bif.o_P} !== exps[i])
        $display("FAIL cc_load_%0d bus=%h got=%b exp=%b", i, vals[i], {bif.o_N, bif.o_Z, bif.o_P}, exps[i]);
      else n_pass++;
      n_total++;
      if ($countones({bif.o_N, bif.o_Z, bif.o_P}) != 1)
        $display("FAIL cc_onehot_%0d got=%b exp=one flag", i, {bif.o_N, bif.o_Z, bif.o_P});
      else n_pass++;
    end
    tick();
    n_total++; if ({bif.o_N, bif.o_Z, bif.o_P} !== 3'b100) $display("FAIL cc_hold got=%b exp=100", {bif.o_N, bif.o_Z, bif.o_P}); else n_pass++;
  endtask

  task automatic test_reset_mid_mul();
    int lat;
    int done_seen;
    start_op(3'b100, 16'h1234, 16'h0005, 16'h0000);
    for (int k = 1; k < 8; k++) tick();
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #2;
    n_total++; if (bif.o_RESULT !== 16'h0000 || bif.o_BUSY !== 1'b0 || bif.o_DONE !== 1'b0)
      $display("FAIL rst_mid_mul got result=%h busy=%b done=%b exp=0000/0/0", bif.o_RESULT, bif.o_BUSY, bif.o_DONE); else n_pass++;
    n_total++; if ({bif.o_N, bif.o_Z, bif.o_P} !== 3'b010) $display("FAIL rst_mid_mul_nzp got=%b exp=010", {bif.o_N, bif.o_Z, bif.o_P}); else n_pass++;
    tick();
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (bif.o_DONE !== 1'b0) done_seen++;
      tick();
    end
    n_total++; if (done_seen != 0) $display("FAIL rst_no_done got=%0d done cycles exp=0", done_seen); else n_pass++;
    start_op(3'b100, 16'h0003, 16'h0004, 16'h0000);
    lat = 1;
    while (bif.o_DONE !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    pop_exp();
    n_total++; if (lat != 17) $display("FAIL mul_latency got=%0d exp=17", lat); else n_pass++;
    n_total++; if (bif.o_RESULT !== exp_v || exp_v !== 16'h000C) $display("FAIL mul_after_rst got=%h exp=%h", bif.o_RESULT, exp_v); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add_imm();
    test_back_to_back();
    test_mul();
    test_cc();
    test_reset_mid_mul();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_execute.md
Name: alu_execute

Overview:
- Execute stage directly downstream of the register file. Consumes the registered SR1/SR2 operands and the IR immediate field.
- Performs the LC-3 ALU operations (ADD, AND, NOT, PASSA) plus an iterative 16-bit MUL extension, and holds the result for gating onto the datapath bus.
- Also owns the N/Z/P condition-code register, which loads from the bus under control-store command.
- Start/busy/done handshake lets the microsequencer stall on multi-cycle MUL.

Parameters:
- WIDTH, 16, datapath word width; only 16 is supported.
- ENABLE_MUL, 1, when 0 the MUL opcode behaves as PASSA and completes in 1 cycle.

Ports:
- i_CLK  input  1  system clock, rising edge.
- i_RST_N  input  1  reset, asynchronous, active-low.
- i_START  input  1  one-cycle pulse; captures operands and opcode.
- i_ALUK  input  3  opcode: 000 ADD, 001 AND, 010 NOT, 011 PASSA, 100 MUL, others = PASSA.
- i_SR1  input  16  operand A, from register file o_SR1.
- i_SR2  input  16  operand B register source, from register file o_SR2.
- i_IR  input  16  instruction register; bit5 selects the immediate, bits[4:0] are imm5.
- i_LD_CC  input  1  load condition codes from i_bus.
- i_bus  input  16  datapath bus.
- o_RESULT  output  16  ALU result; held until the next completion.
- o_BUSY  output  1  high while MUL iterates.
- o_DONE  output  1  one-cycle pulse when o_RESULT is updated.
- o_N, o_Z, o_P  output  1 each  condition codes.

Behaviour:
- Reset (i_RST_N low, asynchronous):
  - State goes to IDLE.
  - o_RESULT=0x0000, o_BUSY=0, o_DONE=0.
  - o_N=0, o_Z=1, o_P=0.
  - MUL accumulator, multiplier and counter cleared.
  - Reset asserted mid-MUL abandons the operation; no o_DONE is produced.
- Operand B is sext(i_IR[4:0]) to 16 bits when i_IR[5]=1, else i_SR2. Only ADD and AND use operand B (plus MUL as multiplier).
- Operands and opcode are sampled only on a rising edge with i_START=1 and state IDLE or DONE. Later changes on i_SR1/i_SR2/i_IR/i_ALUK have no effect on the operation in flight.
- States: IDLE, MUL_RUN, DONE.
  - IDLE + START, non-MUL: result computed from the sampled operands and registered; go to DONE. o_RESULT valid and o_DONE=1 in the cycle after START (latency 1).
  - IDLE + START, MUL (ENABLE_MUL=1): go to MUL_RUN. Accumulator=0, multiplicand=A, multiplier=B, counter=0. o_BUSY=1 from the next cycle.
  - MUL_RUN, each cycle:
    - if multiplier[0], accumulator += multiplicand (mod 2^16);
    - multiplicand <<= 1; multiplier >>= 1; counter++.
    - After the 16th iteration (counter==15 at that edge), o_RESULT=accumulator; go to DONE.
    - MUL latency is 17 cycles START->o_DONE, with o_BUSY high for exactly 16 cycles.
  - DONE: o_DONE=1, o_BUSY=0, lasts one cycle. A START in DONE is accepted exactly as from IDLE (back-to-back). Without START, go to IDLE.
  - START while in MUL_RUN is ignored: no resample, no restart.
- Arithmetic:
  - ADD is 16-bit wrap-around; carry is discarded.
  - NOT is bitwise invert of A.
  - PASSA is A.
  - MUL returns the low 16 bits of the product, which is correct for two's-complement operands without sign handling.
- Condition codes:
  - On a rising edge with i_LD_CC=1, load from i_bus: N=bus[15]; Z=(bus==0); P=!bus[15]&&(bus!=0).
  - Exactly one of N/Z/P is high at all times.
  - i_LD_CC is independent of the ALU state machine and may coincide with START or MUL_RUN.
- o_RESULT changes only on completion or reset.

Test Plan:
- Reset released, no stimulus -> o_RESULT=0x0000, o_BUSY=0, o_DONE=0, N/Z/P=0/1/0.
- ADD immediate: SR1=0x0005, IR[5]=1, IR[4:0]=11101, START -> next cycle o_RESULT=0x0002, o_DONE=1 for one cycle.
- Register-source ops:
  - AND, IR[5]=0, SR1=0x00FF, SR2=0xF0F0 -> 0x00F0.
  - Back-to-back START in the DONE cycle with NOT, SR1=0x1234 -> 0xEDCB one cycle later.
- MUL: SR1=0xFFFD, SR2=0x0007, IR[5]=0, START at cycle t.
  - o_BUSY high for cycles t+1..t+16; o_DONE at t+17 with o_RESULT=0xFFEB.
  - A START with ADD pulsed at t+5 is ignored.
  - Operands changed at t+2 have no effect.
- Condition codes:
  - i_LD_CC with bus=0x8000 -> N=1.
  - Then bus=0x0000 -> Z=1.
  - Then bus=0x7FFF -> P=1.
  - Exactly one flag high after each load; the load asserted during MUL_RUN does not disturb the MUL result.
- MUL started, i_RST_N pulsed low at t+8 -> immediate reset values, no o_DONE. A fresh MUL 0x0003*0x0004 afterwards returns 0x000C at 17-cycle latency.
